// File: rtl/select_max_pkg.sv
// rtl/select_max_pkg.sv - shared state encoding, sentinels and compare helper for the top-k selector
package select_max_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sentinels are built 64 bits wide; callers keep the low w bits.
  function automatic logic [63:0] sent_max(input int w);
    return ~((64'd1 << (w - 1)) - 64'd1);
  endfunction

  function automatic logic [63:0] sent_min(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic better(input longint a, input longint b, input logic find_min);
    return find_min ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/select_max_merge.sv
// rtl/select_max_merge.sv - combinational LANES-wide top-2 reducer with index tracking
module select_max_merge #(
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int IDX_W  = 4
) (
  input  logic                     find_min,
  input  logic [LANES*DATA_W-1:0]  lane_data,
  input  logic [LANES-1:0]         lane_valid,
  input  logic [IDX_W-1:0]         base_idx,
  input  logic signed [DATA_W-1:0] best_in,
  input  logic signed [DATA_W-1:0] second_in,
  input  logic [IDX_W-1:0]         idx_in,
  output logic signed [DATA_W-1:0] best_out,
  output logic signed [DATA_W-1:0] second_out,
  output logic [IDX_W-1:0]         idx_out
);
  import select_max_pkg::*;

  logic signed [DATA_W-1:0] c;

  // Lanes fold in ascending index so the lowest index keeps a tie.
  always_comb begin
    best_out   = best_in;
    second_out = second_in;
    idx_out    = idx_in;
    c          = '0;
    for (int l = 0; l < LANES; l++) begin
      c = lane_data[l*DATA_W +: DATA_W];
      if (lane_valid[l]) begin
        if (better(longint'(c), longint'(best_out), find_min)) begin
          second_out = best_out;
          best_out   = c;
          idx_out    = base_idx + IDX_W'(l);
        end else if (better(longint'(c), longint'(second_out), find_min) || (c == best_out)) begin
          second_out = c;
        end
      end
    end
  end

endmodule

// File: rtl/select_max_topk.sv
// rtl/select_max_topk.sv - multi-lane argmax/argmin with runner-up and margin for the classifier output
module select_max_topk #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 16,
  parameter int LANES     = 1,
  parameter int IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          find_min,
  input  logic [N_CLASSES*DATA_W-1:0]   in_data,
  output logic [IDX_W-1:0]              digit,
  output logic signed [DATA_W-1:0]      max,
  output logic signed [DATA_W-1:0]      runner_up,
  output logic [DATA_W:0]               margin,
  output logic                          layer_done
);
  import select_max_pkg::*;

  localparam int BEATS  = (N_CLASSES + LANES - 1) / LANES;
  localparam int PAD    = BEATS * LANES;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam logic [63:0] SMAX64 = sent_max(DATA_W);
  localparam logic [63:0] SMIN64 = sent_min(DATA_W);
  localparam logic signed [DATA_W-1:0] SENT_MAX = SMAX64[DATA_W-1:0];
  localparam logic signed [DATA_W-1:0] SENT_MIN = SMIN64[DATA_W-1:0];

  state_t                    state, state_nx;
  logic [BEAT_W-1:0]         beat;
  logic                      fm;
  logic [N_CLASSES*DATA_W-1:0] snap;
  logic [PAD*DATA_W-1:0]     snap_pad;
  logic signed [DATA_W-1:0]  best, second, m_best, m_second;
  logic [IDX_W-1:0]          idx, m_idx, base_idx;
  logic [LANES*DATA_W-1:0]   lane_data;
  logic [LANES-1:0]          lane_valid;
  logic [DATA_W:0]           diff;
  logic                      load, step, fin;

  generate
    if (PAD > N_CLASSES) begin : g_pad
      assign snap_pad = {{((PAD - N_CLASSES) * DATA_W){1'b0}}, snap};
    end else begin : g_nopad
      assign snap_pad = snap;
    end
  endgenerate

  // Lanes past the end of the class list are masked rather than zero-filled winners.
  always_comb begin
    lane_data  = '0;
    lane_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      if (int'(beat) * LANES + l < N_CLASSES) begin
        lane_valid[l] = 1'b1;
        lane_data[l*DATA_W +: DATA_W] = snap_pad[(int'(beat) * LANES + l)*DATA_W +: DATA_W];
      end
    end
  end

  assign base_idx = IDX_W'(int'(beat) * LANES);

  select_max_merge #(.DATA_W(DATA_W), .LANES(LANES), .IDX_W(IDX_W)) u_merge (
    .find_min  (fm),
    .lane_data (lane_data),
    .lane_valid(lane_valid),
    .base_idx  (base_idx),
    .best_in   (best),
    .second_in (second),
    .idx_in    (idx),
    .best_out  (m_best),
    .second_out(m_second),
    .idx_out   (m_idx)
  );

  assign diff = fm ? ({second[DATA_W-1], second} - {best[DATA_W-1], best})
                   : ({best[DATA_W-1], best} - {second[DATA_W-1], second});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (enable) state_nx = ST_SCAN;
      ST_SCAN: begin
        if (!enable)                          state_nx = ST_IDLE;
        else if (beat == BEAT_W'(BEATS))      state_nx = ST_DONE;
      end
      ST_DONE: if (!enable) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    load       = (state == ST_IDLE) && enable;
    step       = (state == ST_SCAN) && enable && (beat != BEAT_W'(BEATS));
    fin        = (state == ST_SCAN) && enable && (beat == BEAT_W'(BEATS));
    layer_done = (state == ST_DONE);
  end

  // One extra SCAN edge after the last beat moves the running values into the result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat      <= '0;
      fm        <= 1'b0;
      snap      <= '0;
      best      <= '0;
      second    <= '0;
      idx       <= '0;
      digit     <= '0;
      max       <= '0;
      runner_up <= '0;
      margin    <= '0;
    end else begin
      if (load) begin
        snap   <= in_data;
        fm     <= find_min;
        best   <= find_min ? SENT_MIN : SENT_MAX;
        second <= find_min ? SENT_MIN : SENT_MAX;
        idx    <= '0;
        beat   <= '0;
      end
      if (step) begin
        best   <= m_best;
        second <= m_second;
        idx    <= m_idx;
        beat   <= beat + BEAT_W'(1);
      end
      if (fin) begin
        digit     <= idx;
        max       <= best;
        runner_up <= second;
        margin    <= diff;
      end
    end
  end

endmodule

// File: tb/tb_select_max_topk.sv
// tb/tb_select_max_topk.sv - scoreboard bench for select_max_topk across lane counts and N_CLASSES=1
`timescale 1ns/1ps
module tb_select_max_topk;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic find_min = 1'b0;
  logic [159:0] in_data = '0;

  logic [3:0] d1, d4;
  logic [0:0] dn;
  logic signed [15:0] mx1, mx4, mxn, ru1, ru4, run;
  logic [16:0] mg1, mg4, mgn;
  logic ld1, ld4, ldn;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  select_max_topk #(.N_CLASSES(10), .DATA_W(16), .LANES(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .find_min(find_min), .in_data(in_data),
    .digit(d1), .max(mx1), .runner_up(ru1), .margin(mg1), .layer_done(ld1));

  select_max_topk #(.N_CLASSES(10), .DATA_W(16), .LANES(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .find_min(find_min), .in_data(in_data),
    .digit(d4), .max(mx4), .runner_up(ru4), .margin(mg4), .layer_done(ld4));

  select_max_topk #(.N_CLASSES(1), .DATA_W(16), .LANES(1)) dutn (
    .clk(clk), .reset(reset), .enable(enable), .find_min(find_min), .in_data(in_data[15:0]),
    .digit(dn), .max(mxn), .runner_up(run), .margin(mgn), .layer_done(ldn));

  typedef struct {
    int digit;
    int mx;
    int ru;
    int mg;
    int lat;
    int start;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t qn[$];
  int n_vec = 0;
  int n_bad = 0;
  int vin [10];

  task automatic chk(input string name, input longint got, input longint want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  task automatic check_rsp(input string tag, input exp_t e, input longint d, input longint m,
                           input longint r, input longint g);
    chk({tag, " digit"}, d, e.digit);
    chk({tag, " max"}, m, e.mx);
    chk({tag, " runner_up"}, r, e.ru);
    chk({tag, " margin"}, g, e.mg);
    chk({tag, " latency"}, cyc - e.start, e.lat);
  endtask

  // Monitors: each rising layer_done pops one expected result.
  logic p1 = 1'b0, p4 = 1'b0, pn = 1'b0;
  always @(negedge clk) begin
    if (ld1 && !p1) begin
      if (q1.size() == 0) fail_now("dut1 spurious layer_done");
      else check_rsp("dut1", q1.pop_front(), longint'(d1), longint'(mx1), longint'(ru1), longint'(mg1));
    end
    p1 = ld1;
  end
  always @(negedge clk) begin
    if (ld4 && !p4) begin
      if (q4.size() == 0) fail_now("dut4 spurious layer_done");
      else check_rsp("dut4", q4.pop_front(), longint'(d4), longint'(mx4), longint'(ru4), longint'(mg4));
    end
    p4 = ld4;
  end
  always @(negedge clk) begin
    if (ldn && !pn) begin
      if (qn.size() == 0) fail_now("dutn spurious layer_done");
      else check_rsp("dutn", qn.pop_front(), longint'(dn), longint'(mxn), longint'(run), longint'(mgn));
    end
    pn = ldn;
  end

  task automatic load_inputs(input bit fm);
    find_min = fm;
    for (int k = 0; k < 10; k++) in_data[k*16 +: 16] = 16'(vin[k]);
  endtask

  task automatic push_n1(input bit fm);
    exp_t e;
    e.digit = 0;
    e.mx    = vin[0];
    e.ru    = fm ? 32767 : -32768;
    e.mg    = fm ? (e.ru - vin[0]) : (vin[0] - e.ru);
    e.lat   = 2;
    e.start = cyc + 1;
    qn.push_back(e);
  endtask

  task automatic start_run(input bit fm, input int d, input int mx, input int ru, input int mg);
    exp_t e;
    load_inputs(fm);
    enable = 1'b1;
    e.digit = d; e.mx = mx; e.ru = ru; e.mg = mg; e.start = cyc + 1;
    e.lat = 11; q1.push_back(e);
    e.lat = 4;  q4.push_back(e);
    push_n1(fm);
  endtask

  task automatic run_vec(input bit fm, input int d, input int mx, input int ru, input int mg);
    int t;
    @(negedge clk);
    start_run(fm, d, mx, ru, mg);
    t = 0;
    while (!ld1 && t < 40) begin
      @(negedge clk);
      // Changing the inputs mid-run must not disturb the snapshot.
      if (t == 0) in_data = {10{16'sh4000}};
      t++;
    end
    if (!ld1) fail_now("layer_done timeout");
    @(negedge clk);
    chk("layer_done held while enable high", ld1, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("dut1 layer_done after enable low", ld1, 0);
    chk("dut4 layer_done after enable low", ld4, 0);
    chk("dut1 digit held", d1, d);
    chk("dut4 max held", mx4, mx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset digit", d1, 0);
    chk("reset max", mx1, 0);
    chk("reset runner_up", ru4, 0);
    chk("reset margin", mg4, 0);
    chk("reset layer_done", ld1, 0);
    @(negedge clk);
    reset = 1'b1;

    vin = '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0};
    run_vec(1'b0, 3, 85, 10, 75);
    vin = '{7, -2, 7, 7, 0, 0, 0, 0, 0, 0};
    run_vec(1'b0, 0, 7, 7, 0);
    vin = '{-5, -300, 12, -300, 40, 0, 0, 0, 0, 0};
    run_vec(1'b1, 1, -300, -300, 0);
    vin = '{-32768, 32767, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    run_vec(1'b0, 1, 32767, -32768, 65535);
    vin = '{32767, -32768, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    run_vec(1'b1, 1, -32768, 32767, 65535);
    vin = '{1, 2, 3, 9, 4, 9, 8, 0, 0, 0};
    run_vec(1'b0, 3, 9, 9, 0);
    vin = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 4};
    run_vec(1'b1, 9, 4, 5, 1);
    vin = '{-9, -8, -7, -6, -5, -4, -3, -2, -20, -1};
    run_vec(1'b0, 9, -1, -2, 1);

    // Abort on the 4th SCAN edge; the single-class instance completes before that.
    @(negedge clk);
    vin = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_inputs(1'b0);
    push_n1(1'b0);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort dut1 layer_done", ld1, 0);
      chk("abort dut4 layer_done", ld4, 0);
    end
    chk("abort dut1 digit kept", d1, 9);
    chk("abort dut1 max kept", mx1, -1);
    chk("abort dut4 runner_up kept", ru4, -2);
    chk("abort dut4 margin kept", mg4, 1);

    vin = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    run_vec(1'b0, 5, 9, 6, 3);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    vin = '{0, 0, 0, 50, 0, 0, 0, 0, 0, 0};
    start_run(1'b0, 3, 50, 0, 50);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async reset dut1 digit", d1, 0);
    chk("async reset dut1 max", mx1, 0);
    chk("async reset dut4 runner_up", ru4, 0);
    chk("async reset dut4 margin", mg4, 0);
    chk("async reset dut1 layer_done", ld1, 0);
    q1.delete();
    q4.delete();
    qn.delete();
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    vin = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    run_vec(1'b1, 0, -1, -1, 0);

    repeat (3) @(negedge clk);
    chk("dut1 scoreboard drained", q1.size(), 0);
    chk("dut4 scoreboard drained", q4.size(), 0);
    chk("dutn scoreboard drained", qn.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/select_max_topk.md
Name: select_max_topk

Overview:
Parametrised argmax/argmin unit for the classifier output layer: it scans N_CLASSES signed scores, LANES per cycle, and reports the winning class index, winning score, runner-up score and decision margin. It replaces the fixed 10-input select_max behind the final dense layer and uses the same enable / layer_done handshake with the layer sequencer. A per-run mode selects max or min search.

Parameters:
N_CLASSES, 10, number of input scores (>=1)
DATA_W, 16, signed score width
LANES, 1, scores compared per clock (1..N_CLASSES)
IDX_W, $clog2(N_CLASSES) (min 1), width of the class index

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  level request; run starts when high in IDLE, must stay high until layer_done
find_min  in  1  0 = argmax, 1 = argmin; sampled at run start
in_data  in  signed [DATA_W-1:0] x N_CLASSES  score array; sampled at run start
digit  out  IDX_W  winning class index
max  out  signed DATA_W  winning score
runner_up  out  signed DATA_W  second-best score
margin  out  unsigned DATA_W+1  |max - runner_up|
layer_done  out  1  result valid; held until enable falls

Behaviour:
- Reset (reset=0, async): state IDLE; digit=0, max=0, runner_up=0, margin=0, layer_done=0; snapshot and running registers cleared.
- BEATS = ceil(N_CLASSES/LANES). FSM: IDLE, SCAN, DONE.
- IDLE: edge with enable=1 -> copy in_data into the snapshot and latch find_min. Init best=SENT, second=SENT, idx=0, beat=0. Go to SCAN. SENT = -2^(DATA_W-1) for max mode, 2^(DATA_W-1)-1 for min mode.
- SCAN: each edge processes beat b (snapshot indices b*LANES .. b*LANES+LANES-1). Lanes at index >= N_CLASSES are masked and never win.
- Merge order is ascending index. For candidate c at index i: if c strictly better than best -> second=best, best=c, idx=i; else if c strictly better than second or c==best -> second=c. "Better" is > in max mode and < in min mode.
- Tie-break: the lowest index wins; a duplicate of the best value becomes runner_up.
- After the last beat: outputs are registered from the final running values (digit=idx, max=best, runner_up=second). margin = best-second in max mode, second-best in min mode, computed in DATA_W+1 bits with no overflow. Next state DONE with layer_done=1.
- Latency: layer_done rises BEATS+1 rising edges after the edge that sampled enable=1 in IDLE.
- DONE: outputs stable, layer_done=1 while enable=1. Edge with enable=0 -> IDLE, layer_done=0; result outputs hold their values until the next completion.
- Abort: enable=0 during SCAN -> IDLE on that edge. Results are not updated and layer_done stays 0.
- in_data changes after the start edge are ignored until the next run.
- N_CLASSES=1: digit=0, max=in_data[0], runner_up=SENT, margin=|in_data[0]-SENT|.
- Async reset mid-run returns to IDLE immediately with all outputs cleared.

Decomposition:
- select_max_pkg: fsm state enum (IDLE/SCAN/DONE), sentinel functions sent_max(W)/sent_min(W), compare function better(a,b,find_min).
- Sub-module select_max_merge: combinational LANES-wide top-2 reducer with index tracking and lane valid mask. It takes the running {best,second,idx} and returns updated values, so the top level holds only the FSM, beat counter, snapshot and output registers.

Test Plan:
- N=10, LANES=1, max mode, in={0,0,5,85,0,10,0,0,0,0}, enable held -> layer_done after 11 edges; digit=3, max=85, runner_up=10, margin=75.
- Same vector with LANES=4 (BEATS=3, last beat 2 lanes masked) -> layer_done after 4 edges, same results; masked lanes never selected.
- Ties, in={7,-2,7,7,...,0} max mode -> digit=0, max=7, runner_up=7, margin=0.
- Min mode, in={-5,-300,12,-300,40,...} -> digit=1, max=-300, runner_up=-300, margin=0. Extremes {-32768,32767}, max mode -> digit=1, margin=65535.
- Abort: drop enable on the 4th SCAN cycle -> layer_done never asserts, outputs keep prior run values. Re-raise enable -> a clean full run.
- Async reset asserted mid-SCAN -> all outputs 0 immediately. Handshake: enable low in DONE -> layer_done low on the next edge, outputs held.
